// File: rtl/fft_seq.sv
// fft_seq -- frame sequencer for a pipelined radix-2 FFT chain.
//
// Accepts a gapless sample stream marked by start-of-frame and runs the
// master frame counter cnt0. Each stage k gets a delayed copy of the count,
// (cnt0 - k*STG_LAT) mod N, so that it reads cnt = 0 on the cycle sample 0
// arrives there. Sample validity and start-of-frame travel down a TOT-deep
// shift register to flag the last stage output. After the final frame the
// sequencer keeps counting for TOT cycles (FLUSH) so the pipeline drains.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      sample present on stage-0 din
//   in_sof        with in_valid: sample 0 of a frame
//   err_clr       synchronous pulse clearing err (a new error the same cycle wins)
//   stg_cnt       NSTG slices of CBW bits; slice k is stage k's cnt
//   out_valid     last-stage dout holds a valid result
//   out_sof       with out_valid: first sample of an output frame
//   busy          sequencer is not idle
//   err           sticky; [0] gap inside a frame, [1] sof off the frame boundary
module fft_seq #(
    parameter int CBW     = 3,
    parameter int NSTG    = 3,
    parameter int STG_LAT = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic                 err_clr,
    output logic [NSTG*CBW-1:0]  stg_cnt,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 busy,
    output logic [1:0]           err
);
    localparam int N   = 1 << CBW;
    localparam int TOT = NSTG * STG_LAT;
    localparam int DW  = $clog2(TOT + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state, state_nx;
    logic [CBW-1:0]  cnt0, cnt0_nx;
    logic [DW-1:0]   drain, drain_nx;
    logic [1:0]      err_nx;
    logic            acc_valid, acc_sof;
    logic            boundary, start;
    logic [TOT-1:0]  vld_pipe, sof_pipe;

    assign boundary = (cnt0 == '0);
    assign start    = in_valid & in_sof;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cnt0_nx   = cnt0 + 1'b1;
        drain_nx  = drain;
        err_nx    = err_clr ? 2'b00 : err;
        acc_valid = 1'b0;
        unique case (state)
            IDLE: begin
                drain_nx  = '0;
                acc_valid = start;
                if (start) state_nx = RUN;
                else       cnt0_nx  = '0;
            end
            RUN: begin
                if (boundary) begin
                    if (start) begin
                        acc_valid = 1'b1;           // back-to-back frame
                    end else if (TOT == 1) begin
                        state_nx = IDLE;
                        cnt0_nx  = '0;
                        drain_nx = '0;
                    end else begin
                        state_nx = FLUSH;
                        drain_nx = DW'(1);          // this cycle is the first drain cycle
                    end
                end else begin
                    // Mid-frame: a missing sample is a gap, a stray sof is a
                    // sync error; the count is never resynced.
                    acc_valid = in_valid;
                    if (!in_valid) err_nx[0] = 1'b1;
                    if (start)     err_nx[1] = 1'b1;
                end
            end
            FLUSH: begin
                drain_nx = drain + DW'(1);
                if (boundary && start) begin
                    state_nx  = RUN;
                    drain_nx  = '0;
                    acc_valid = 1'b1;
                end else begin
                    if (!boundary && start) err_nx[1] = 1'b1;
                    if (drain_nx == DW'(TOT)) begin
                        state_nx = IDLE;
                        cnt0_nx  = '0;
                        drain_nx = '0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt0_nx  = '0;
                drain_nx = '0;
            end
        endcase
    end

    // cnt0 is 0 on every accepted frame start, so the sof flag is just the boundary.
    assign acc_sof = acc_valid & boundary;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0     <= '0;
            drain    <= '0;
            err      <= 2'b00;
            vld_pipe <= '0;
            sof_pipe <= '0;
        end else begin
            cnt0     <= cnt0_nx;
            drain    <= drain_nx;
            err      <= err_nx;
            vld_pipe <= (vld_pipe << 1) | TOT'(acc_valid);
            sof_pipe <= (sof_pipe << 1) | TOT'(acc_sof);
        end
    end

    assign out_valid = vld_pipe[TOT-1];
    assign out_sof   = sof_pipe[TOT-1];
    assign busy      = (state != IDLE);

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam logic [CBW-1:0] OFF = CBW'((k * STG_LAT) % N);
        assign stg_cnt[k*CBW +: CBW] = cnt0 - OFF;
    end
endmodule

// File: tb/tb_fft_seq.sv
// Scoreboard bench for fft_seq (CBW=3, NSTG=2, STG_LAT=5 -> N=8, TOT=10).
// Stimulus is generated as whole frames; each accepted sample pushes the
// cycle at which its output flag must appear. A separate monitor pops an
// entry whenever out_valid is high.
module tb_fft_seq;
    localparam int CBW     = 3;
    localparam int NSTG    = 2;
    localparam int STG_LAT = 5;
    localparam int N       = 1 << CBW;
    localparam int TOT     = NSTG * STG_LAT;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0, in_sof = 1'b0, err_clr = 1'b0;
    logic [NSTG*CBW-1:0] stg_cnt;
    logic                out_valid, out_sof, busy;
    logic [1:0]          err;

    fft_seq #(.CBW(CBW), .NSTG(NSTG), .STG_LAT(STG_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .err_clr(err_clr), .stg_cnt(stg_cnt), .out_valid(out_valid),
        .out_sof(out_sof), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { int cyc; logic sof; } exp_t;
    exp_t q[$];

    int n_cmp = 0, n_bad = 0;
    logic [1:0] exp_err = 2'b00, exp_err_nx = 2'b00;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output flag must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("out_valid_unexpected", int'(out_valid), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("out_sof", int'(out_sof), int'(e.sof));
                end
            end else begin
                chk("out_sof_without_valid", int'(out_sof), 0);
            end
        end
    end

    // One input cycle. mid marks a frame slot other than sample 0, where a
    // missing sample or a stray sof is an error.
    task automatic step(input logic v, input logic s, input logic clr, input bit mid);
        @(posedge clk);
        exp_err = exp_err_nx;
        #1;
        in_valid = v; in_sof = s; err_clr = clr;
        exp_err_nx = clr ? 2'b00 : exp_err;
        if (mid && !v)     exp_err_nx[0] = 1'b1;
        if (mid && v && s) exp_err_nx[1] = 1'b1;
        @(negedge clk);
        chk("err", int'(err), int'(exp_err));
    endtask

    function automatic int modn(input int x);
        return ((x % N) + N) % N;
    endfunction

    task automatic check_cnt(input int pos);
        logic [NSTG*CBW-1:0] sc;
        sc = stg_cnt;
        for (int k = 0; k < NSTG; k++)
            chk($sformatf("stg_cnt%0d", k), int'(sc[k*CBW +: CBW]), modn(pos - k*STG_LAT));
    endtask

    // One frame; bit j of the masks applies to sample j (bit 0 ignored).
    task automatic frame(input logic [N-1:0] gapm, input logic [N-1:0] sofm,
                         input logic [N-1:0] clrm);
        for (int j = 0; j < N; j++) begin
            logic v, s;
            v = (j == 0) ? 1'b1 : !gapm[j];
            s = (j == 0) ? 1'b1 : (v & sofm[j]);
            step(v, s, clrm[j], j != 0);
            if (v) q.push_back('{cyc: cyc + TOT, sof: (j == 0)});
            check_cnt(j);
            if (j != 0) chk("busy_in_frame", int'(busy), 1);
        end
    endtask

    // Idle inputs right after a frame; busy stays high for the TOT drain cycles.
    task automatic idle_after(input int g, input int clr_at);
        for (int i = 0; i < g; i++) begin
            step(1'b0, 1'b0, (i == clr_at), 1'b0);
            chk("busy_drain", int'(busy), (i < TOT) ? 1 : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #13;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        check_cnt(0);
        @(negedge clk); rst = 1'b0;

        // Idle; stray in_valid without sof is ignored
        for (int i = 0; i < 20; i++) begin
            step((i == 5 || i == 6), 1'b0, 1'b0, 1'b0);
            chk("idle_busy", int'(busy), 0);
            check_cnt(0);
        end

        // Single clean frame
        frame('0, '0, '0);
        idle_after(14, -1);

        // Three back-to-back frames
        for (int f = 0; f < 3; f++) frame('0, '0, '0);
        idle_after(12, -1);

        // Gap at sample 4, then clear during idle
        frame(8'h10, '0, '0);
        idle_after(12, 11);

        // Stray sof at sample 3; clear during flush with no new error
        frame('0, 8'h08, '0);
        idle_after(12, 5);

        // Sync error at sample 1, then err_clr together with a gap at sample 4
        frame(8'h10, 8'h02, 8'h10);
        idle_after(12, 11);

        // Reset pulse mid-frame at cnt0 = 5
        for (int j = 0; j <= 5; j++) begin
            step(1'b1, (j == 0), 1'b0, j != 0);
            q.push_back('{cyc: cyc + TOT, sof: (j == 0)});
        end
        #2;
        rst = 1'b1;
        q.delete();
        in_valid = 1'b0; in_sof = 1'b0;
        #1;
        chk("rstmid_out_valid", int'(out_valid), 0);
        chk("rstmid_out_sof", int'(out_sof), 0);
        chk("rstmid_busy", int'(busy), 0);
        check_cnt(0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 2'b00; exp_err_nx = 2'b00;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        frame('0, '0, '0);
        idle_after(12, -1);

        // Randomized sessions; a gap of N restarts from FLUSH on a boundary
        for (int sess = 0; sess < 8; sess++) begin
            int nfr, g;
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                logic [N-1:0] gm, sm;
                gm = '0; sm = '0;
                for (int j = 1; j < N; j++) begin
                    gm[j] = ($urandom_range(0, 7) == 0);
                    sm[j] = ($urandom_range(0, 9) == 0);
                end
                frame(gm, sm, '0);
            end
            g = ($urandom_range(0, 2) == 0) ? N : $urandom_range(TOT, TOT + 4);
            idle_after(g, g - 1);
        end

        for (int i = 0; i < TOT + 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("scoreboard_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
